// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit XNOR LFSR generator/checker pair.
package lfsr_pkg;

  // All-ones is the one state an XNOR LFSR can never leave.
  localparam logic [31:0] LFSR_32_LOCKUP = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One shift of the taps-32,22,2,1 XNOR LFSR. A chain of three XNORs
  // collapses to the inverted XOR of the four taps.
  function automatic logic [31:0] lfsr_32_next(input logic [31:0] v);
    return {v[30:0], ~(v[31] ^ v[21] ^ v[1] ^ v[0])};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  // Count register: clear first, then increment unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
    end else if (clr) begin
      value_reg <= '0;
    end else if (inc && (value_reg != {WIDTH{1'b1}})) begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/lfsr_32_checker.sv
// Receive-side checker for the 32-bit XNOR LFSR stream: seeds from the
// input, verifies a run of matches, then flywheels its own prediction and
// counts mismatching words while locked.
module lfsr_32_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_value,
  input  logic                   clear_counters,
  output logic                   locked,
  output logic                   error_pulse,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int MRUN_W = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT)   : 1;
  localparam int BRUN_W = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
  // Run values at which the next event completes the run.
  localparam logic [MRUN_W-1:0] MATCH_LAST = MRUN_W'(LOCK_COUNT - 1);
  localparam logic [BRUN_W-1:0] BAD_LAST   = BRUN_W'(UNLOCK_COUNT - 1);

  chk_state_t        state_reg, state_next;
  logic [31:0]       expected_reg, expected_next;
  logic [MRUN_W-1:0] match_reg, match_next;
  logic [BRUN_W-1:0] bad_reg, bad_next;
  logic              locked_reg;
  logic              error_pulse_reg, error_next;
  logic [1:0]        cnt_inc;       // [0] err_count, [1] word_count
  logic [COUNT_WIDTH-1:0] cnt_value [2];

  logic word_match;
  assign word_match = (in_value == expected_reg);

  // Next-state: seeding, verification and flywheel tracking of the stream.
  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    match_next    = match_reg;
    bad_next      = bad_reg;
    error_next    = 1'b0;
    cnt_inc       = 2'b00;
    if (in_valid) begin
      unique case (state_reg)
        SEARCH: begin
          if (in_value != LFSR_32_LOCKUP) begin
            expected_next = lfsr_32_next(in_value);
            match_next    = '0;
            state_next    = VERIFY;
          end
        end
        VERIFY: begin
          if (word_match) begin
            expected_next = lfsr_32_next(expected_reg);
            if (match_reg == MATCH_LAST) begin
              match_next = '0;
              bad_next   = '0;
              state_next = LOCKED;
            end else begin
              match_next = match_reg + 1'b1;
            end
          end else begin
            // A lock-up word is no usable seed; keep the old prediction.
            if (in_value != LFSR_32_LOCKUP) begin
              expected_next = lfsr_32_next(in_value);
            end
            match_next = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never follows the received data.
          expected_next = lfsr_32_next(expected_reg);
          cnt_inc[1]    = 1'b1;
          if (word_match) begin
            bad_next = '0;
          end else begin
            error_next = 1'b1;
            cnt_inc[0] = 1'b1;
            if (bad_reg == BAD_LAST) begin
              bad_next   = '0;
              state_next = SEARCH;
            end else begin
              bad_next = bad_reg + 1'b1;
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  // State, prediction, run counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= SEARCH;
      expected_reg    <= '0;
      match_reg       <= '0;
      bad_reg         <= '0;
      locked_reg      <= 1'b0;
      error_pulse_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      expected_reg    <= expected_next;
      match_reg       <= match_next;
      bad_reg         <= bad_next;
      locked_reg      <= (state_next == LOCKED);
      error_pulse_reg <= error_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_counters),
        .inc   (cnt_inc[gi]),
        .value (cnt_value[gi])
      );
    end
  endgenerate

  assign locked      = locked_reg;
  assign error_pulse = error_pulse_reg;
  assign err_count   = cnt_value[0];
  assign word_count  = cnt_value[1];

endmodule

// File: tb/tb_lfsr_32_checker.sv
// Directed bench for lfsr_32_checker: lock acquisition, single and burst
// errors, lock-up words, idle gaps, counter clear and mid-stream reset.
module tb_lfsr_32_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_value = '0;
  logic        clear_counters = 1'b0;
  logic        locked;
  logic        error_pulse;
  logic [31:0] err_count;
  logic [31:0] word_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] gen_word;

  // Hand-computed start of the sequence from init 0.
  logic [31:0] t1_words [11] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h9, 32'h12,
                                 32'h24, 32'h49, 32'h92, 32'h124, 32'h249};

  always #5 clk = ~clk;

  lfsr_32_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(4), .COUNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_value       (in_value),
    .clear_counters (clear_counters),
    .locked         (locked),
    .error_pulse    (error_pulse),
    .err_count      (err_count),
    .word_count     (word_count)
  );

  // Reference generator step: feedback is the inverted parity of the taps.
  function automatic logic [31:0] model_next(input logic [31:0] v);
    logic [3:0] taps;
    taps = {v[31], v[21], v[1], v[0]};
    return (v << 1) | {31'b0, ~(^taps)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic clr);
    in_valid       = v;
    in_value       = w;
    clear_counters = clr;
    @(posedge clk);
    #1;
    $display("t=%0t valid=%0b word=%08h clr=%0b -> locked=%0b pulse=%0b err=%0d words=%0d",
             $time, v, w, clr, locked, error_pulse, err_count, word_count);
  endtask

  // Sends the next clean generator word.
  task automatic send_clean();
    step(1'b1, gen_word, 1'b0);
    gen_word = model_next(gen_word);
  endtask

  initial begin
    // Reset state.
    #3 rst_n = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", error_pulse, 0);
    check("rst_err", err_count, 0);
    check("rst_words", word_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Lock on the sequence from init 0: seed + 8 matches.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, t1_words[i], 1'b0);
      if (i < 8)       check("t1_not_locked", locked, 0);
      else if (i == 8) check("t1_locked", locked, 1);
      else             check("t1_words", word_count, 32'(i - 8));
    end
    check("t1_err", err_count, 0);
    gen_word = model_next(t1_words[10]);

    // 2. One corrupted word (bit 5), then a clean word proves no reseed.
    step(1'b1, gen_word ^ 32'h20, 1'b0);
    gen_word = model_next(gen_word);
    check("t2_pulse", error_pulse, 1);
    check("t2_err", err_count, 1);
    check("t2_locked", locked, 1);
    send_clean();
    check("t2_pulse_clear", error_pulse, 0);
    check("t2_err_hold", err_count, 1);
    check("t2_words", word_count, 4);

    // 3. Four corrupted words drop lock; relock needs 9 valid words.
    step(1'b0, '0, 1'b1);
    check("t3_clr_err", err_count, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gen_word ^ 32'h20, 1'b0);
      gen_word = model_next(gen_word);
      check("t3_pulse", error_pulse, 1);
      check("t3_locked", locked, (i < 3) ? 32'd1 : 32'd0);
    end
    check("t3_err", err_count, 4);
    for (int i = 0; i < 9; i++) begin
      send_clean();
      check("t3_relock", locked, (i == 8) ? 32'd1 : 32'd0);
    end
    check("t3_err_after", err_count, 4);
    check("t3_words_after", word_count, 4);

    // 5. Idle gap while locked.
    for (int i = 0; i < 10; i++) step(1'b0, 32'hDEAD_BEEF, 1'b0);
    check("t5_locked", locked, 1);
    check("t5_words", word_count, 4);
    send_clean();
    check("t5_pulse", error_pulse, 0);
    check("t5_err", err_count, 4);
    check("t5_words_resume", word_count, 5);

    // 6. Clear in the same cycle as a mismatch.
    step(1'b1, gen_word ^ 32'h1, 1'b1);
    gen_word = model_next(gen_word);
    check("t6_err_clr", err_count, 0);
    check("t6_words_clr", word_count, 0);
    check("t6_pulse", error_pulse, 1);
    check("t6_locked", locked, 1);

    // Asynchronous reset while locked.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_pulse", error_pulse, 0);
    check("arst_err", err_count, 0);
    check("arst_words", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4. Lock-up words in SEARCH are ignored.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'hFFFF_FFFF, 1'b0);
      check("t4_locked", locked, 0);
      check("t4_pulse", error_pulse, 0);
    end
    check("t4_err", err_count, 0);
    check("t4_words", word_count, 0);

    // Relock after reset needs 1 + LOCK_COUNT words.
    for (int i = 0; i < 9; i++) begin
      send_clean();
      check("rl_locked", locked, (i == 8) ? 32'd1 : 32'd0);
    end
    send_clean();
    check("rl_words", word_count, 1);
    check("rl_err", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
